// File: rtl/bus_timer_slave_pkg.sv
// Shared bus-slave constants and timer register map.
package bus_timer_slave_pkg;

   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;
   localparam logic READ     = 1'b1;
   localparam logic WRITE    = 1'b0;

   localparam int unsigned WORD_DATA_W = 32;

   localparam logic [1:0] TIMER_ADDR_CTRL    = 2'd0;
   localparam logic [1:0] TIMER_ADDR_INTR    = 2'd1;
   localparam logic [1:0] TIMER_ADDR_EXPR    = 2'd2;
   localparam logic [1:0] TIMER_ADDR_COUNTER = 2'd3;

   localparam int unsigned TIMER_START_LOC = 0;
   localparam int unsigned TIMER_MODE_LOC  = 1;
   localparam int unsigned TIMER_IRQ_LOC   = 0;

   typedef enum logic {StIdle, StWait} hs_state_e;

endpackage

// File: rtl/bus_slave_handshake.sv
// Generic slave-bus handshake: accepts an access, counts wait states, pulses rdy_.
module bus_slave_handshake
   import bus_timer_slave_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic       clk,
   input  logic       reset_,
   input  logic       cs_,
   input  logic       as_,
   input  logic       rw,
   input  logic [1:0] addr,
   output logic       accept,
   output logic       fire,
   output logic [1:0] fire_addr,
   output logic       fire_rw,
   output logic       rdy_
);

   localparam logic [3:0] WcntInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   hs_state_e  state_q, state_d;
   logic [3:0] wcnt_q, wcnt_d;
   logic [1:0] addr_q, addr_d;
   logic       rw_q, rw_d;
   logic       rdy_q;

   // Next-state: accept in IDLE, count down in WAIT, abort when deselected.
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      addr_d    = addr_q;
      rw_d      = rw_q;
      accept    = 1'b0;
      fire      = 1'b0;
      fire_addr = addr_q;
      fire_rw   = rw_q;
      unique case (state_q)
         StIdle: begin
            if (cs_ == ENABLE_ && as_ == ENABLE_) begin
               accept = 1'b1;
               addr_d = addr;
               rw_d   = rw;
               if (WAIT_CYCLES == 0) begin
                  // Zero wait states: the accepting edge is also the ready edge.
                  fire      = 1'b1;
                  fire_addr = addr;
                  fire_rw   = rw;
               end else begin
                  state_d = StWait;
                  wcnt_d  = WcntInit;
               end
            end
         end
         StWait: begin
            if (cs_ == DISABLE_) begin
               state_d = StIdle;
            end else if (wcnt_q == 4'd0) begin
               fire    = 1'b1;
               state_d = StIdle;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Handshake state and registered rdy_ pulse.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q <= StIdle;
         wcnt_q  <= 4'd0;
         addr_q  <= 2'd0;
         rw_q    <= READ;
         rdy_q   <= DISABLE_;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         addr_q  <= addr_d;
         rw_q    <= rw_d;
         rdy_q   <= fire ? ENABLE_ : DISABLE_;
      end
   end

   assign rdy_ = rdy_q;

endmodule

// File: rtl/bus_timer_slave.sv
// Slave-bus interval timer: CTRL/INTR/EXPR/COUNTER registers with expiry interrupt.
module bus_timer_slave
   import bus_timer_slave_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 0,
   parameter int unsigned CNT_W       = 32
) (
   input  logic        clk,
   input  logic        reset_,
   input  logic        cs_,
   input  logic        as_,
   input  logic        rw,
   input  logic [29:0] addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        rdy_,
   output logic        irq
);

   logic             accept, fire, fire_rw;
   logic [1:0]       fire_addr;
   logic             start_q, start_d, mode_q, mode_d, intr_q, intr_d;
   logic [CNT_W-1:0] expr_q, expr_d, counter_q, counter_d;
   logic [31:0]      rd_val, rd_data_q;
   logic             wr_en, expire;
   logic             unused_addr;

   assign unused_addr = ^addr[29:2];

   bus_slave_handshake #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_handshake (
      .clk       (clk),
      .reset_    (reset_),
      .cs_       (cs_),
      .as_       (as_),
      .rw        (rw),
      .addr      (addr[1:0]),
      .accept    (accept),
      .fire      (fire),
      .fire_addr (fire_addr),
      .fire_rw   (fire_rw),
      .rdy_      (rdy_)
   );

   assign wr_en  = accept && (rw == WRITE);
   assign expire = start_q && (counter_q == expr_q);

   // Register next-state; bus writes take priority over timer side effects,
   // except that an expiry wins over a software clear of the flag.
   always_comb begin
      start_d   = start_q;
      mode_d    = mode_q;
      intr_d    = intr_q;
      expr_d    = expr_q;
      counter_d = counter_q;
      if (expire) begin
         counter_d = '0;
         intr_d    = 1'b1;
         if (!mode_q) start_d = 1'b0;
      end else if (start_q) begin
         counter_d = counter_q + 1'b1;
      end
      if (wr_en) begin
         unique case (addr[1:0])
            TIMER_ADDR_CTRL: begin
               start_d = wr_data[TIMER_START_LOC];
               mode_d  = wr_data[TIMER_MODE_LOC];
            end
            TIMER_ADDR_INTR: begin
               if (wr_data[TIMER_IRQ_LOC] && !expire) intr_d = 1'b0;
            end
            TIMER_ADDR_EXPR:    expr_d    = wr_data[CNT_W-1:0];
            TIMER_ADDR_COUNTER: counter_d = wr_data[CNT_W-1:0];
            default: ;
         endcase
      end
   end

   // Read mux, sampled at the edge that asserts rdy_.
   always_comb begin
      rd_val = '0;
      unique case (fire_addr)
         TIMER_ADDR_CTRL: begin
            rd_val[TIMER_START_LOC] = start_q;
            rd_val[TIMER_MODE_LOC]  = mode_q;
         end
         TIMER_ADDR_INTR:    rd_val[TIMER_IRQ_LOC] = intr_q;
         TIMER_ADDR_EXPR:    rd_val = WORD_DATA_W'(expr_q);
         TIMER_ADDR_COUNTER: rd_val = WORD_DATA_W'(counter_q);
         default: ;
      endcase
   end

   // Timer registers and the registered read-data return.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         start_q   <= 1'b0;
         mode_q    <= 1'b0;
         intr_q    <= 1'b0;
         expr_q    <= '0;
         counter_q <= '0;
         rd_data_q <= '0;
      end else begin
         start_q   <= start_d;
         mode_q    <= mode_d;
         intr_q    <= intr_d;
         expr_q    <= expr_d;
         counter_q <= counter_d;
         rd_data_q <= (fire && fire_rw == READ) ? rd_val : '0;
      end
   end

   assign rd_data = rd_data_q;
   assign irq     = intr_q;

endmodule

// File: tb/tb_bus_timer_slave.sv
// Directed bench: one timer with no wait states, one with three.
module tb_bus_timer_slave;

   logic        clk, reset_, cs0_, cs3_, as_, rw;
   logic [29:0] addr;
   logic [31:0] wr_data, rd0, rd3;
   logic        rdy0_, rdy3_, irq0, irq3;
   int          checks = 0;
   int          errors = 0;

   localparam logic       R = 1'b1, W = 1'b0;
   localparam logic [1:0] A_CTRL = 2'd0, A_INTR = 2'd1, A_EXPR = 2'd2, A_CNT = 2'd3;

   bus_timer_slave #(.WAIT_CYCLES(0), .CNT_W(32)) dut0 (
      .clk(clk), .reset_(reset_), .cs_(cs0_), .as_(as_), .rw(rw), .addr(addr),
      .wr_data(wr_data), .rd_data(rd0), .rdy_(rdy0_), .irq(irq0)
   );

   bus_timer_slave #(.WAIT_CYCLES(3), .CNT_W(32)) dut3 (
      .clk(clk), .reset_(reset_), .cs_(cs3_), .as_(as_), .rw(rw), .addr(addr),
      .wr_data(wr_data), .rd_data(rd3), .rdy_(rdy3_), .irq(irq3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Zero-wait access on dut0; returns just after the accepting edge (rdy0_ low).
   task automatic bus0(input logic r, input logic [1:0] a, input logic [31:0] d);
      cs0_ = 1'b0; as_ = 1'b0; rw = r; addr = {28'h0, a}; wr_data = d;
      tick();
      as_ = 1'b1; cs0_ = 1'b1;
   endtask

   // Three-wait access on dut3; returns in the rdy3_ low cycle.
   task automatic bus3(input logic r, input logic [1:0] a, input logic [31:0] d);
      cs3_ = 1'b0; as_ = 1'b0; rw = r; addr = {28'h0, a}; wr_data = d;
      tick();
      as_ = 1'b1;
      tick(); tick(); tick();
      cs3_ = 1'b1;
   endtask

   initial begin
      reset_ = 1'b0; cs0_ = 1'b1; cs3_ = 1'b1; as_ = 1'b1; rw = R; addr = '0; wr_data = '0;
      tick();
      chk("rst_rdy0", {31'h0, rdy0_}, 32'h1);
      chk("rst_rdy3", {31'h0, rdy3_}, 32'h1);
      chk("rst_rd0", rd0, 32'h0);
      chk("rst_irq0", {31'h0, irq0}, 32'h0);
      reset_ = 1'b1;
      tick();

      // 1: zero wait states, write then read EXPR
      bus0(W, A_EXPR, 32'd5);
      chk("t1_wr_rdy", {31'h0, rdy0_}, 32'h0);
      chk("t1_wr_rd", rd0, 32'h0);
      tick();
      chk("t1_wr_rdy_off", {31'h0, rdy0_}, 32'h1);
      bus0(R, A_EXPR, 32'h0);
      chk("t1_rd_rdy", {31'h0, rdy0_}, 32'h0);
      chk("t1_rd_data", rd0, 32'h5);
      tick();
      chk("t1_rd_rdy_off", {31'h0, rdy0_}, 32'h1);
      chk("t1_rd_idle", rd0, 32'h0);

      // 2: three wait states, read CTRL, extra as_ pulse during WAIT
      cs3_ = 1'b0; as_ = 1'b0; rw = R; addr = {28'h0, A_CTRL};
      tick();
      as_ = 1'b1;
      chk("t2_c1", {31'h0, rdy3_}, 32'h1);
      as_ = 1'b0;
      tick();
      as_ = 1'b1;
      chk("t2_c2", {31'h0, rdy3_}, 32'h1);
      tick();
      chk("t2_c3", {31'h0, rdy3_}, 32'h1);
      tick();
      chk("t2_c4", {31'h0, rdy3_}, 32'h0);
      chk("t2_data", rd3, 32'h0);
      cs3_ = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t2_no_extra", {31'h0, rdy3_}, 32'h1);
      end

      // 3: one-shot timer
      bus0(W, A_EXPR, 32'd3); tick();
      bus0(W, A_CTRL, 32'h1);
      bus0(R, A_CNT, 32'h0);
      chk("t3_cnt0", rd0, 32'h0);
      tick();
      bus0(R, A_CNT, 32'h0);
      chk("t3_cnt2", rd0, 32'h2);
      chk("t3_irq_pre", {31'h0, irq0}, 32'h0);
      tick();
      chk("t3_irq_fire", {31'h0, irq0}, 32'h1);
      bus0(R, A_CNT, 32'h0);
      chk("t3_cnt_reload", rd0, 32'h0);
      tick();
      bus0(R, A_CTRL, 32'h0);
      chk("t3_ctrl_clr", rd0, 32'h0);
      tick();
      bus0(R, A_INTR, 32'h0);
      chk("t3_intr", rd0, 32'h1);
      tick();
      bus0(W, A_INTR, 32'h0);
      chk("t3_w0_noclr", {31'h0, irq0}, 32'h1);
      tick();
      bus0(W, A_INTR, 32'h1);
      chk("t3_w1_clr", {31'h0, irq0}, 32'h0);
      tick();

      // 4: periodic timer, expiry every 3 cycles
      bus0(W, A_EXPR, 32'd2); tick();
      bus0(W, A_CTRL, 32'h3);
      tick(); tick();
      chk("t4_p2", {31'h0, irq0}, 32'h0);
      tick();
      chk("t4_p3", {31'h0, irq0}, 32'h1);
      bus0(W, A_INTR, 32'h1);
      chk("t4_p4_clr", {31'h0, irq0}, 32'h0);
      tick();
      chk("t4_p5", {31'h0, irq0}, 32'h0);
      tick();
      chk("t4_p6", {31'h0, irq0}, 32'h1);
      tick(); tick();
      bus0(W, A_INTR, 32'h1);
      chk("t4_p9_race", {31'h0, irq0}, 32'h1);
      bus0(W, A_INTR, 32'h1);
      chk("t4_p10_clr", {31'h0, irq0}, 32'h0);
      bus0(W, A_CTRL, 32'h0);
      tick();

      // 5: counter wrap
      bus0(W, A_EXPR, 32'h10); tick();
      bus0(W, A_CNT, 32'hFFFF_FFFF); tick();
      bus0(W, A_CTRL, 32'h1);
      tick();
      bus0(R, A_CNT, 32'h0);
      chk("t5_wrap", rd0, 32'h0);
      for (int i = 0; i < 15; i++) tick();
      chk("t5_irq_pre", {31'h0, irq0}, 32'h0);
      tick();
      chk("t5_irq_16", {31'h0, irq0}, 32'h1);
      bus0(W, A_CTRL, 32'h0); tick();

      // 6: abort mid-WAIT keeps the committed write
      cs3_ = 1'b0; as_ = 1'b0; rw = W; addr = {28'h0, A_EXPR}; wr_data = 32'h77;
      tick();
      as_ = 1'b1;
      tick();
      cs3_ = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t6_abort_rdy", {31'h0, rdy3_}, 32'h1);
      end
      bus3(R, A_EXPR, 32'h0);
      chk("t6_expr_rdy", {31'h0, rdy3_}, 32'h0);
      chk("t6_expr", rd3, 32'h77);
      tick();

      // 6: reset mid-WAIT with irq pending
      bus3(W, A_EXPR, 32'h1); tick();
      bus3(W, A_CTRL, 32'h1);
      chk("t6_irq_set", {31'h0, irq3}, 32'h1);
      tick();
      cs3_ = 1'b0; as_ = 1'b0; rw = R; addr = {28'h0, A_CNT};
      tick();
      as_ = 1'b1;
      tick();
      reset_ = 1'b0;
      #1;
      chk("t6_rst_rdy", {31'h0, rdy3_}, 32'h1);
      chk("t6_rst_irq", {31'h0, irq3}, 32'h0);
      chk("t6_rst_rd", rd3, 32'h0);
      tick(); tick();
      reset_ = 1'b1; cs3_ = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t6_no_pulse", {31'h0, rdy3_}, 32'h1);
      end
      bus3(R, A_CTRL, 32'h0);
      chk("t6_ctrl0", rd3, 32'h0);
      tick();
      bus3(R, A_INTR, 32'h0);
      chk("t6_intr0", rd3, 32'h0);
      tick();
      bus3(R, A_EXPR, 32'h0);
      chk("t6_expr0", rd3, 32'h0);
      tick();
      bus3(R, A_CNT, 32'h0);
      chk("t6_cnt0", rd3, 32'h0);
      tick();
      bus0(R, A_EXPR, 32'h0);
      chk("t6_dut0_expr0", rd0, 32'h0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_timer_slave.md
Name: bus_timer_slave

Overview:
Bus-side responder for the shared slave bus. It decodes a chip-selected access, inserts a configurable number of wait states and returns read data on its slot's rd_data/rdy_ pair to the slave return multiplexer. The slave hosts a 32-bit interval timer with four word registers: CTRL, INTR, EXPR and COUNTER. It raises irq on expiry and occupies one slave slot, s0 to s7.

Parameters:
WAIT_CYCLES, 0, wait states inserted before rdy_ is driven low (0..15)
CNT_W, 32, counter/expiry width (equals WORD_DATA_W)

Ports:
clk  in  1  system clock, all state on rising edge
reset_  in  1  asynchronous, active-low reset
cs_  in  1  chip select, active-low (ENABLE_ = 0)
as_  in  1  address strobe, active-low, one-cycle pulse starting an access
rw  in  1  READ = 1, WRITE = 0
addr  in  30  word address; only addr[1:0] decoded (0 CTRL, 1 INTR, 2 EXPR, 3 COUNTER), rest ignored
wr_data  in  32  write data
rd_data  out  32  read data, valid only while rdy_ = 0, else 32'h0
rdy_  out  1  ready, active-low, one-cycle pulse
irq  out  1  timer interrupt, active-high, equals INTR[0]

Behaviour:
- Reset (async, reset_ = 0):
  - rd_data = 0, rdy_ = DISABLE_ (1), irq = 0.
  - All registers are 0.
  - The handshake FSM goes to IDLE.
  - Reset mid-transaction abandons the access with no rdy_ pulse.
- Handshake FSM states: IDLE, WAIT.
  - IDLE: an edge with cs_ = 0 and as_ = 0 accepts the access (edge E0) and latches addr[1:0] and rw.
  - Writes commit to the target register at E0.
  - If WAIT_CYCLES = 0: rdy_ = 0 in the cycle after E0, state stays IDLE.
  - Otherwise: go to WAIT with wcnt = WAIT_CYCLES-1.
  - WAIT: decrement wcnt each edge. At the edge where wcnt = 0, drive rdy_ = 0 for the following cycle and return to IDLE.
  - rdy_ is low exactly one cycle, beginning WAIT_CYCLES cycles after the cycle following E0.
  - Read data is the register value sampled at the edge that asserts rdy_, so a read of COUNTER sees the live count at that edge. Writes return rd_data = 0.
  - as_ while in WAIT, or on the edge that asserts rdy_, is ignored; no queuing.
  - cs_ = 1 while in WAIT aborts: return to IDLE with no rdy_ pulse. A write already committed at E0 stays committed.
  - as_ = 0 with cs_ = 1 is ignored.
- Registers:
  - CTRL: bit0 start, bit1 periodic; other bits read 0.
  - INTR: bit0 expired flag. Writing 1 to bit0 clears it; writing 0 has no effect.
  - EXPR: expiry value, full width.
  - COUNTER: read/write.
- Timer:
  - When start = 1, COUNTER increments by 1 each cycle, wrapping at 2^CNT_W-1 to 0.
  - When COUNTER == EXPR with start = 1: on that edge set INTR[0], load COUNTER = 0, and clear start if periodic = 0.
  - EXPR = 0 with start = 1 fires every cycle.
- Simultaneous events:
  - Bus write to COUNTER beats increment or expiry reload.
  - Bus write to CTRL beats the automatic start clear.
  - Expiry set beats a software clear of INTR in the same edge: flag stays 1.
- irq is the registered INTR[0]; no extra latency beyond the register.

Decomposition:
- Shared header gets ENABLE_, DISABLE_, READ, WRITE and WORD_DATA_W.
- Shared header also gets the timer register index constants (TIMER_ADDR_CTRL/INTR/EXPR/COUNTER) and the CTRL/INTR bit positions (TIMER_START_LOC, TIMER_MODE_LOC, TIMER_IRQ_LOC).
- One sub-module: bus_slave_handshake. It holds the IDLE/WAIT FSM, wait counter, abort and rdy_ generation, and is parameterised by WAIT_CYCLES. Later slaves reuse it.
- Timer datapath and register file stay in bus_timer_slave.

Test Plan:
1. WAIT_CYCLES = 0: write EXPR = 32'd5, then read EXPR -> rdy_ low exactly one cycle after each accepting edge; read rd_data = 32'h5; rd_data = 0 whenever rdy_ = 1.
2. WAIT_CYCLES = 3: read CTRL after reset -> rdy_ low only in the 4th cycle after E0, rd_data = 0; a second as_ pulse issued in WAIT produces no extra rdy_.
3. One-shot timer: EXPR = 3, CTRL = 32'h1 -> COUNTER 0,1,2,3; on the expiry edge irq = 1, COUNTER = 0, CTRL reads 0; irq stays 1 until INTR is written with 32'h1, then irq = 0.
4. Periodic timer: EXPR = 2, CTRL = 32'h3 -> INTR[0] set every 3 cycles; a software clear on the same edge as expiry leaves irq = 1.
5. Write COUNTER = 32'hFFFF_FFFF with EXPR = 32'h10 and start = 1 -> wraps to 0 the next cycle, no irq until count reaches 16.
6. Abort and reset: cs_ deasserted mid-WAIT -> no rdy_, but a write of EXPR is visible on the next read. Then reset_ = 0 mid-WAIT -> rdy_ = 1, irq = 0, all registers read 0 after release.
